// File: rtl/data_memory_ext.sv
// rtl/data_memory_ext.sv - byte-addressed data memory with sized stores and extended, pipelined loads
module data_memory_ext #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [DATA_WIDTH-1:0] Read_data,
  output logic                  Read_valid,
  output logic                  Fault
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] MAX_BYTES = 4'(NBYTES);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [OFF-1:0]        byte_off;
  logic [3:0]            n_bytes;
  logic [7:0]            size_mask;
  logic                  legal;
  logic                  wr_go;
  logic                  rd_go;
  logic                  unused_addr_bits;

  // Upper address bits are deliberately ignored so the array aliases.
  assign word_idx         = Address[ADDR_WIDTH+OFF-1:OFF];
  assign byte_off         = Address[OFF-1:0];
  assign unused_addr_bits = ^Address;

  always_comb begin
    n_bytes   = 4'd1;
    size_mask = 8'h01;
    case (Size)
      2'b00: begin
        n_bytes   = 4'd1;
        size_mask = 8'h01;
      end
      2'b01: begin
        n_bytes   = 4'd2;
        size_mask = 8'h03;
      end
      2'b10: begin
        n_bytes   = 4'd4;
        size_mask = 8'h0F;
      end
      default: begin
        n_bytes   = 4'd8;
        size_mask = 8'hFF;
      end
    endcase
  end

  assign legal = ((Address[3:0] & (n_bytes - 4'd1)) == 4'd0) && (n_bytes <= MAX_BYTES);
  assign wr_go = MemWrite && legal;
  assign rd_go = MemRead && !MemWrite;

  logic [NBYTES-1:0]     byte_en;
  logic [DATA_WIDTH-1:0] bit_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] wr_word;

  // Sub-word stores are a read-modify-write of the addressed word.
  always_comb begin
    bit_en   = '0;
    byte_en  = size_mask[NBYTES-1:0] << byte_off;
    for (int b = 0; b < NBYTES; b++) begin
      bit_en[8*b +: 8] = {8{byte_en[b]}};
    end
    wdata_sh = Write_data << {byte_off, 3'b000};
    wr_word  = (mem[word_idx] & ~bit_en) | (wdata_sh & bit_en);
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_go) begin
      mem[word_idx] <= wr_word;
    end
  end

  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] low_mask;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  sign_bit;

  always_comb begin
    rd_sh    = mem[word_idx] >> {byte_off, 3'b000};
    low_mask = '1;
    sign_bit = rd_sh[DATA_WIDTH-1];
    case (Size)
      2'b00: begin
        low_mask = DATA_WIDTH'(8'hFF);
        sign_bit = rd_sh[7];
      end
      2'b01: begin
        low_mask = DATA_WIDTH'(16'hFFFF);
        sign_bit = rd_sh[15];
      end
      2'b10: begin
        low_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit = rd_sh[31];
      end
      default: begin
        low_mask = '1;
        sign_bit = rd_sh[DATA_WIDTH-1];
      end
    endcase
    load_val = rd_sh & low_mask;
    if (!Unsigned && sign_bit) begin
      load_val = load_val | ~low_mask;
    end
    if (!legal) begin
      load_val = '0;
    end
  end

  logic [DATA_WIDTH-1:0] pipe_data  [READ_LATENCY];
  logic                  pipe_valid [READ_LATENCY];
  logic                  pipe_fault [READ_LATENCY];
  logic                  wr_fault_q;

  // Data stages only advance behind a valid slot, so the last stage holds the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_fault[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
      wr_fault_q <= 1'b0;
    end else begin
      pipe_valid[0] <= rd_go;
      pipe_fault[0] <= rd_go && !legal;
      if (rd_go) begin
        pipe_data[0] <= load_val;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_fault[i] <= pipe_fault[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
      wr_fault_q <= MemWrite && !legal;
    end
  end

  assign Read_data  = pipe_data[READ_LATENCY-1];
  assign Read_valid = pipe_valid[READ_LATENCY-1];
  assign Fault      = wr_fault_q | pipe_fault[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_ext.sv
// tb/tb_data_memory_ext.sv - directed test of data_memory_ext (32b/lat1 and 64b/lat3) against a byte-level model
module tb_data_memory_ext;

  localparam int NE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [2];
  logic [31:0] addr  [2];
  logic [63:0] wdata [2];
  logic        we    [2];
  logic        re    [2];
  logic        uns   [2];
  logic [1:0]  sz    [2];

  logic [31:0] rd32;
  logic        v32, f32;
  logic [63:0] rd64;
  logic        v64, f64;

  data_memory_ext #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1)) u32 (
    .clk(clk), .rst(rst_v[0]), .Address(addr[0]), .Write_data(wdata[0][31:0]),
    .MemWrite(we[0]), .MemRead(re[0]), .Size(sz[0]), .Unsigned(uns[0]),
    .Read_data(rd32), .Read_valid(v32), .Fault(f32)
  );

  data_memory_ext #(.ADDR_WIDTH(6), .DATA_WIDTH(64), .READ_LATENCY(3)) u64 (
    .clk(clk), .rst(rst_v[1]), .Address(addr[1]), .Write_data(wdata[1]),
    .MemWrite(we[1]), .MemRead(re[1]), .Size(sz[1]), .Unsigned(uns[1]),
    .Read_data(rd64), .Read_valid(v64), .Fault(f64)
  );

  // Model: byte-addressed memory plus expected outputs indexed by edge number.
  logic [7:0]  mb    [2][4096];
  logic        exp_v [2][NE];
  logic        exp_f [2][NE];
  logic        exp_r [2][NE];
  logic [63:0] exp_d [2][NE];
  logic [63:0] hold  [2];
  int edge_n = 0;
  int last_t = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  function automatic int lat(int d);   return (d == 1) ? 3 : 1;      endfunction
  function automatic int nbytes(int d); return (d == 1) ? 8 : 4;     endfunction
  function automatic int total(int d);  return (d == 1) ? 512 : 4096; endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic model_step(int d, int t);
    int n, a, due;
    bit ok;
    logic [63:0] v, m;
    if (rst_v[d]) begin
      for (int k = t; k < t + 8; k++) begin
        exp_v[d][k] = 1'b0;
        exp_f[d][k] = 1'b0;
      end
      exp_r[d][t] = 1'b1;
      return;
    end
    if (!we[d] && !re[d]) return;
    n  = 1 << sz[d];
    a  = int'(addr[d] % 32'(total(d)));
    ok = (addr[d] % 32'(n) == 0) && (n <= nbytes(d));
    if (we[d]) begin
      if (ok) begin
        for (int i = 0; i < n; i++) mb[d][a+i] = wdata[d][8*i +: 8];
      end else begin
        exp_f[d][t] = 1'b1;
      end
    end else begin
      due = t + lat(d) - 1;
      exp_v[d][due] = 1'b1;
      v = '0;
      if (ok) begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][a+i];
        if (n < 8) begin
          m = (64'd1 << (8*n)) - 64'd1;
          if (!uns[d] && v[8*n-1]) v = v | ~m;
        end
        if (d == 0) v = v & 64'hFFFF_FFFF;
      end else begin
        exp_f[d][due] = 1'b1;
      end
      exp_d[d][due] = v;
    end
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'b0; re[d] = 1'b0; addr[d] = '0; wdata[d] = '0; sz[d] = 2'b00; uns[d] = 1'b0;
    end
  endtask

  task automatic step();
    int t;
    t = edge_n + 1;
    model_step(0, t);
    model_step(1, t);
    last_t = t;
    @(posedge clk);
    edge_n = t;
    #1;
    idle();
  endtask

  task automatic op(int d, bit w, bit r, logic [31:0] a, logic [63:0] wd, logic [1:0] s, bit u);
    we[d] = w; re[d] = r; addr[d] = a; wdata[d] = wd; sz[d] = s; uns[d] = u;
    step();
  endtask

  task automatic st(int d, logic [31:0] a, logic [63:0] wd, logic [1:0] s);
    op(d, 1'b1, 1'b0, a, wd, s, 1'b0);
  endtask

  task automatic ld(int d, logic [31:0] a, logic [1:0] s, bit u);
    op(d, 1'b0, 1'b1, a, 64'd0, s, u);
  endtask

  // Hand-computed literals that pin the model's prediction for the last load issued.
  task automatic lit(string nm, int d, logic [63:0] want_d, logic want_f);
    int due;
    due = last_t + lat(d) - 1;
    chk({nm, "_valid"}, 64'(exp_v[d][due]), 64'd1);
    chk({nm, "_data"},  exp_d[d][due], want_d);
    chk({nm, "_fault"}, 64'(exp_f[d][due]), 64'(want_f));
  endtask

  always @(negedge clk) begin : cmp
    int t;
    logic [63:0] gd;
    logic gv, gf;
    if (edge_n >= 1) begin
      t = edge_n;
      for (int d = 0; d < 2; d++) begin
        if (exp_r[d][t]) hold[d] = '0;
        if (exp_v[d][t]) hold[d] = exp_d[d][t];
        gd = (d == 1) ? rd64 : {32'd0, rd32};
        gv = (d == 1) ? v64 : v32;
        gf = (d == 1) ? f64 : f32;
        chk($sformatf("valid%0d@%0d", d, t), 64'(gv), 64'(exp_v[d][t]));
        chk($sformatf("fault%0d@%0d", d, t), 64'(gf), 64'(exp_f[d][t]));
        chk($sformatf("data%0d@%0d", d, t), gd, hold[d]);
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      hold[d] = '0;
      for (int k = 0; k < NE; k++) begin
        exp_v[d][k] = 1'b0; exp_f[d][k] = 1'b0; exp_r[d][k] = 1'b0; exp_d[d][k] = '0;
      end
    end
    idle();
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    step(); step();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    step();

    // 32-bit, latency 1
    st(0, 32'h40, 64'hDEADBEEF, 2'b10);
    ld(0, 32'h40, 2'b10, 1'b0);            lit("word", 0, 64'hDEADBEEF, 1'b0);
    st(0, 32'h41, 64'h80, 2'b00);
    ld(0, 32'h41, 2'b00, 1'b0);            lit("sbyte", 0, 64'hFFFFFF80, 1'b0);
    ld(0, 32'h41, 2'b00, 1'b1);            lit("ubyte", 0, 64'h00000080, 1'b0);
    ld(0, 32'h40, 2'b10, 1'b0);            lit("merged", 0, 64'hDEAD80EF, 1'b0);
    ld(0, 32'h43, 2'b01, 1'b0);            lit("mis_half", 0, 64'h0, 1'b1);
    st(0, 32'h42, 64'h11223344, 2'b10);
    chk("mis_store_fault", 64'(exp_f[0][last_t]), 64'd1);
    ld(0, 32'h40, 2'b10, 1'b0);            lit("after_mis", 0, 64'hDEAD80EF, 1'b0);
    ld(0, 32'h43, 2'b00, 1'b0);            lit("sbyte_hi", 0, 64'hFFFFFFDE, 1'b0);
    ld(0, 32'h40, 2'b11, 1'b0);            lit("size11_32", 0, 64'h0, 1'b1);
    st(0, 32'h48, 64'h1, 2'b11);
    ld(0, 32'h2040, 2'b10, 1'b1);          lit("alias", 0, 64'hDEAD80EF, 1'b0);
    st(0, 32'h44, 64'hABCD8001, 2'b01);
    ld(0, 32'h44, 2'b01, 1'b0);            lit("shalf", 0, 64'hFFFF8001, 1'b0);
    ld(0, 32'h44, 2'b01, 1'b1);            lit("uhalf", 0, 64'h00008001, 1'b0);
    st(0, 32'h2046, 64'h1234, 2'b01);
    ld(0, 32'h46, 2'b01, 1'b0);            lit("alias_half", 0, 64'h1234, 1'b0);
    ld(0, 32'h44, 2'b10, 1'b0);            lit("two_halves", 0, 64'h12348001, 1'b0);
    op(0, 1'b1, 1'b1, 32'h50, 64'h55667788, 2'b10, 1'b0);
    chk("dual_no_valid", 64'(exp_v[0][last_t]), 64'd0);
    ld(0, 32'h50, 2'b10, 1'b0);            lit("dual_wrote", 0, 64'h55667788, 1'b0);
    step(); step();

    // 64-bit, latency 3
    st(1, 32'h0, 64'd1, 2'b10);
    st(1, 32'h4, 64'd2, 2'b10);
    st(1, 32'h8, 64'd3, 2'b10);
    st(1, 32'hC, 64'd4, 2'b10);
    ld(1, 32'h0, 2'b10, 1'b1);             lit("b2b_0", 1, 64'd1, 1'b0);
    ld(1, 32'h4, 2'b10, 1'b1);             lit("b2b_1", 1, 64'd2, 1'b0);
    ld(1, 32'h8, 2'b10, 1'b1);             lit("b2b_2", 1, 64'd3, 1'b0);
    ld(1, 32'hC, 2'b10, 1'b1);             lit("b2b_3", 1, 64'd4, 1'b0);
    st(1, 32'h8, 64'h0123456789ABCDEF, 2'b11);
    ld(1, 32'hE, 2'b01, 1'b0);             lit("dw_half", 1, 64'h0000000000000123, 1'b0);
    ld(1, 32'h8, 2'b11, 1'b0);             lit("dw_full", 1, 64'h0123456789ABCDEF, 1'b0);
    ld(1, 32'h8, 2'b10, 1'b0);             lit("dw_sword", 1, 64'hFFFFFFFF89ABCDEF, 1'b0);
    ld(1, 32'hC, 2'b10, 1'b0);             lit("dw_hiword", 1, 64'h0000000001234567, 1'b0);
    ld(1, 32'h8, 2'b00, 1'b1);             lit("dw_ubyte", 1, 64'h00000000000000EF, 1'b0);
    ld(1, 32'h4, 2'b11, 1'b0);             lit("dw_mis", 1, 64'h0, 1'b1);
    step(); step(); step();

    ld(1, 32'h0, 2'b10, 1'b0);
    ld(1, 32'h4, 2'b10, 1'b0);
    rst_v[1] = 1'b1;
    step();
    rst_v[1] = 1'b0;
    chk("rst_flush_a", 64'(exp_v[1][last_t]), 64'd0);
    chk("rst_flush_b", 64'(exp_v[1][last_t+1]), 64'd0);
    step(); step();
    ld(1, 32'h0, 2'b10, 1'b1);             lit("retained", 1, 64'd1, 1'b0);
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ext.md
Name: data_memory_ext

Overview:
Parametrised successor to the single-cycle data memory of the MIPS datapath. It supports byte, halfword, word and (for 64-bit builds) doubleword loads and stores on a byte-addressed bus. Loads are sign- or zero-extended and pass through a configurable read pipeline with a valid strobe; misaligned or illegal accesses raise a fault flag. The block sits in the MEM stage, driven by the control unit's MemRead/MemWrite plus the new size and sign controls.

Parameters:
ADDR_WIDTH, 10, log2 of depth in words (the array holds 2**ADDR_WIDTH words)
DATA_WIDTH, 32, word width; legal values 32 or 64
READ_LATENCY, 1, cycles from accepted read to Read_valid; legal range 1..4

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
Address  input  32  byte address
Write_data  input  DATA_WIDTH  store data, right-justified (low bits used for sub-word stores)
MemWrite  input  1  store request, sampled each edge
MemRead  input  1  load request, sampled each edge
Size  input  2  00 byte, 01 half, 10 word(32b), 11 doubleword (DATA_WIDTH=64 only)
Unsigned  input  1  1 = zero-extend load, 0 = sign-extend
Read_data  output  DATA_WIDTH  extended load result
Read_valid  output  1  one-cycle strobe marking Read_data valid
Fault  output  1  one-cycle strobe: access misaligned or Size illegal

Behaviour:
- OFF = log2(DATA_WIDTH/8). Word index = Address[ADDR_WIDTH+OFF-1:OFF]; byte offset = Address[OFF-1:0]. Higher address bits are ignored, so the address wraps modulo the array size.
- Access bytes N = 1/2/4/8 per Size. The access is legal only if Address mod N = 0 and N <= DATA_WIDTH/8. Size=11 with DATA_WIDTH=32 is illegal.
- Store (MemWrite=1, legal): write Write_data[8N-1:0] into bytes offset..offset+N-1 of the addressed word at the edge. All other bytes are unchanged.
- Store (illegal): no array change; Fault pulses in the cycle after the edge.
- MemWrite and MemRead both high: the write has priority, the read is dropped, and Read_valid does not pulse for it.
- Load (MemRead=1, MemWrite=0), accepted at edge t:
  - The array is read at edge t and the extraction result propagates through READ_LATENCY-1 further register stages.
  - Read_valid=1 and Read_data are valid in the cycle following edge t+READ_LATENCY-1.
  - Extraction: take bytes offset..offset+N-1, then sign-extend (Unsigned=0) or zero-extend to DATA_WIDTH. Size and Unsigned are captured at acceptance.
- Illegal load: no array effect. At the same pipeline slot, Read_valid=1, Fault=1 and Read_data=0.
- Throughput is one access per cycle. Back-to-back loads produce back-to-back Read_valid in issue order.
- Ordering: a store at edge t is visible to a load accepted at edge t+1 or later.
- Read_data holds its last value while Read_valid=0.
- Fault timing: for stores, Fault is aligned to the cycle after the edge. For loads, Fault is aligned with Read_valid.
- Reset (rst=1 at an edge):
  - Read_data=0, Read_valid=0, Fault=0.
  - All in-flight pipeline slots are flushed; no Read_valid is ever produced for loads accepted before or during reset.
  - MemWrite/MemRead in a reset cycle are ignored.
  - Array contents are not reset.
- No X propagation: unused pipeline slots carry valid=0.

Test Plan:
1. DATA_WIDTH=32, LAT=1: store word 0xDEADBEEF @0x40, load word @0x40 next cycle -> Read_valid in the cycle after the load edge, Read_data=0xDEADBEEF, Fault=0.
2. Byte store 0x80 @0x41, then load byte signed @0x41 -> 0xFFFFFF80. Unsigned load -> 0x00000080. Word @0x40 -> 0xDEAD80EF.
3. Load half @0x43 and store word @0x42 -> both Fault=1. The load gives Read_data=0 with Read_valid=1; a subsequent word read @0x40 still returns 0xDEAD80EF.
4. LAT=3: loads on four consecutive cycles @0x0,0x4,0x8,0xC holding 1,2,3,4 -> Read_valid high for four consecutive cycles starting 3 cycles after the first edge, data 1,2,3,4 in order.
5. LAT=3: issue two loads, assert rst on the next edge -> no Read_valid ever appears. Outputs are 0 after reset; memory still holds prior data.
6. DATA_WIDTH=64: doubleword store 0x0123456789ABCDEF @0x8, signed half load @0xE -> 0x0000000000000123. Size=11 with DATA_WIDTH=32 -> Fault. With ADDR_WIDTH=10, address 0x2040 aliases 0x0040.
